bit_deserializer8: RTL and testbench

BIT_DESERIALIZER8 -- requirements
Module: bit_deserializer8

---
 rtl/bit_deserializer8_pkg.sv | 12 +
 rtl/bit_deserializer8_demux8_1.sv | 16 +
 rtl/bit_deserializer8.sv | 94 +++++++++
 tb/tb_bit_deserializer8.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_deserializer8_pkg.sv
// Shared constants and state encoding for the 8-bit serial-to-parallel deserializer.
package bit_deserializer8_pkg;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/bit_deserializer8_demux8_1.sv
// 1-to-8 demultiplexer: routes the enable onto the one-hot line picked by the select.
module demux8_1
    import bit_deserializer8_pkg::*;
(
    input  logic [IDX_W-1:0] sel_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] onehot_o
);

    // NOTE: default every output first in always_comb so no path can infer a latch.
    always_comb begin
        onehot_o        = '0;
        onehot_o[sel_i] = en_i;
    end

endmodule

// File: rtl/bit_deserializer8.sv
// Serial-to-parallel deserializer: assembles 8 accepted bits LSB-first and presents
// the word with a valid/ready handshake; a transfer may overlap the next word's first bit.
module bit_deserializer8
    import bit_deserializer8_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] idx
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] out_q;

    logic             accept;
    logic             xfer;
    logic [IDX_W-1:0] wr_sel;
    logic [WIDTH-1:0] wr_en;
    logic [WIDTH-1:0] bit_en;
    logic [WIDTH-1:0] bit_d;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = (state_q == FILL) || out_ready;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // A bit accepted while the held word leaves always starts the next word at out[0].
    assign wr_sel = (state_q == HOLD) ? '0 : idx_q;

    demux8_1 u_demux (
        .sel_i    (wr_sel),
        .en_i     (accept && !clear),
        .onehot_o (wr_en)
    );

    // Each flop loads on clear, on word hand-off, or on its own write strobe;
    // loaded value is the incoming bit only when strobed, otherwise zero.
    assign bit_en = {WIDTH{clear || xfer}} | wr_en;
    assign bit_d  = wr_en & {WIDTH{in_bit}};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (clear) begin
            state_d = FILL;
            idx_d   = '0;
        end else if (state_q == FILL) begin
            if (accept) begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    state_d = HOLD;
                end
            end
        end else if (xfer) begin
            state_d = FILL;
            idx_d   = accept ? IDX_W'(1) : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the word register is reset because a discarded word must never reappear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                if (bit_en[k]) begin
                    out_q[k] <= bit_d[k];
                end
            end
        end
    end

    assign out = out_q;
    assign idx = idx_q;

endmodule

// File: tb/tb_bit_deserializer8.sv
// Scoreboard bench for bit_deserializer8: directed scenarios followed by 1000 words of gapped traffic.
module tb_bit_deserializer8;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic       m_hold;
    logic [2:0] m_idx;
    logic [7:0] m_word;
    int         n_xfer;
    logic [7:0] exp_q[$];

    bit_deserializer8 dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idx       (idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edges as the DUT, using only the driven inputs.
    always @(posedge clk or posedge reset) begin
        logic [7:0] w;
        if (reset || clear) begin
            m_hold <= 1'b0;
            m_idx  <= 3'd0;
            m_word <= 8'h00;
            exp_q.delete();
        end else if (m_hold) begin
            if (out_ready) begin
                n_xfer <= n_xfer + 1;
                m_hold <= 1'b0;
                if (in_valid) begin
                    m_word <= 8'h01 & {8{in_bit}};
                    m_idx  <= 3'd1;
                end else begin
                    m_word <= 8'h00;
                    m_idx  <= 3'd0;
                end
            end
        end else if (in_valid) begin
            w        = m_word;
            w[m_idx] = in_bit;
            m_word  <= w;
            m_idx   <= m_idx + 3'd1;
            if (m_idx == 3'd7) begin
                m_hold <= 1'b1;
                exp_q.push_back(w);
            end
        end
    end

    // Monitor: sampled on the falling edge, pops the scoreboard on every transfer.
    always @(negedge clk) begin
        logic [7:0] e;
        check("in_ready", in_ready, m_hold ? out_ready : 1'b1);
        check("out_valid", out_valid, m_hold);
        check("idx", idx, m_idx);
        check("out_vs_model", out, m_word);
        if (m_hold && out_ready && !reset && !clear) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("word", out, e);
            end
        end
    end

    // Apply inputs, then advance to 1 time unit after the next rising edge.
    task automatic cyc(input logic v, input logic b, input logic ordy, input logic clr);
        in_valid  = v;
        in_bit    = b;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out"}, out, 8'h00);
        check({tag, "_idx"}, idx, 3'd0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] seq;
        int         base;
        int         budget;

        n_xfer    = 0;
        reset     = 1'b1;
        clear     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Bits 1,0,1,1,0,0,1,0 first-to-last land at out[0..7] -> 8'h4D.
        seq = 8'b0100_1101;
        for (int i = 0; i < 8; i++) cyc(1'b1, seq[i], 1'b0, 1'b0);
        check("fill_out_valid", out_valid, 1'b1);
        check("fill_out", out, 8'h4D);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_idx", idx, 3'd0);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, i[0], 1'b0, 1'b0);
            check("hold_out", out, 8'h4D);
            check("hold_idx", idx, 3'd0);
            check("hold_valid", out_valid, 1'b1);
        end

        // Transfer with coincident accept: no bubble.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("overlap_valid", out_valid, 1'b0);
        check("overlap_out", out, 8'h01);
        check("overlap_idx", idx, 3'd1);

        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("three_bits_out", out, 8'h07);
        check("three_bits_idx", idx, 3'd3);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("clear_out", out, 8'h00);
        check("clear_idx", idx, 3'd0);
        check("clear_valid", out_valid, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_idx", idx, 3'd0);
        check("idle_out", out, 8'h00);

        // Asynchronous reset mid-word at idx 5.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_out", out, 8'h1F);
        check("mid_idx", idx, 3'd5);
        #2 reset = 1'b1;
        #1 check_reset_values("async_mid");
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_reset_out", out, 8'h01);
        check("post_reset_idx", idx, 3'd1);

        // Asynchronous reset while holding a word.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_hold_reset_valid", out_valid, 1'b1);
        check("pre_hold_reset_out", out, 8'h01);
        #2 reset = 1'b1;
        #1 check_reset_values("async_hold");
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // 8'hA5 sent LSB first, then a transfer with no accept.
        seq = 8'hA5;
        for (int i = 0; i < 8; i++) cyc(1'b1, seq[i], 1'b0, 1'b0);
        check("a5_out", out, 8'hA5);
        check("a5_valid", out_valid, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("drain_out", out, 8'h00);
        check("drain_idx", idx, 3'd0);
        check("drain_valid", out_valid, 1'b0);

        // Gapped traffic until 1000 further words have been handed off.
        base   = n_xfer;
        budget = 0;
        while ((n_xfer - base) < 1000 && budget < 60000) begin
            cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0, 1'b0);
            budget++;
        end
        check("random_words_done", (n_xfer - base) >= 1000, 1'b1);

        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
